// File: rtl/spi_send_pkg.sv
// Shared types and defaults for the SPI slave transmit path.
package spi_send_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_send_fifo.sv
// First-word-fall-through byte buffer; pointers carry one extra wrap bit.
module spi_send_fifo
  import spi_send_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic   [AW:0]   wr_ptr;
  logic   [AW:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_send.sv
// SPI mode-0 slave transmitter fed by an AXI4-Stream byte buffer.
// Define SPI_SEND_LSB_FIRST_EN for LSB-first shifting (default MSB first).
module spi_send
  import spi_send_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  IDLE_BYTE  = IDLE_BYTE_DEFAULT
) (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       spi_clk,
  input  logic       spi_cs,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       axis_tvalid,
  output logic       axis_tready,
  input  logic [7:0] axis_tdata,
  input  logic       axis_tlast,
  output logic       underrun,
  output logic       frame_done
);

  state_t     state;
  logic [2:0] clk_sync;
  logic [2:0] cs_sync;
  logic       clk_rise, clk_fall, cs_rise, cs_fall;
  logic       ready_en;
  logic       full, empty, pop;
  entry_t     head, push_entry;
  logic [7:0] load_byte;
  logic [7:0] shreg;
  logic       last_flag;
  logic [2:0] bit_cnt;
  logic       byte_done;

  // Stages [1:0] synchronize, stage [2] is the history flop for edge detection.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      clk_sync <= '0;
      cs_sync  <= '1;
      ready_en <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], spi_clk};
      cs_sync  <= {cs_sync[1:0], spi_cs};
      ready_en <= 1'b1;
    end
  end

  assign clk_rise = clk_sync[1] && !clk_sync[2];
  assign clk_fall = !clk_sync[1] && clk_sync[2];
  assign cs_rise  = cs_sync[1] && !cs_sync[2];
  assign cs_fall  = !cs_sync[1] && cs_sync[2];

  assign axis_tready = ready_en && !full;
  assign push_entry  = {axis_tlast, axis_tdata};
  // Never pop when deselect lands on the LOAD cycle, so no byte is silently lost.
  assign pop         = (state == LOAD) && !cs_rise && !empty;
  assign load_byte   = empty ? IDLE_BYTE : head.data;

  spi_send_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .push      (axis_tvalid && axis_tready),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= IDLE;
      shreg       <= '0;
      last_flag   <= 1'b0;
      bit_cnt     <= '0;
      byte_done   <= 1'b0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
      underrun    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      if (cs_rise) begin
        state       <= IDLE;
        spi_miso    <= 1'b1;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
            if (cs_fall) state <= LOAD;
          end
          LOAD: begin
            shreg       <= load_byte;
            last_flag   <= !empty && head.last;
            underrun    <= empty;
`ifdef SPI_SEND_LSB_FIRST_EN
            spi_miso    <= load_byte[0];
`else
            spi_miso    <= load_byte[7];
`endif
            spi_miso_oe <= 1'b1;
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            state       <= SHIFT;
          end
          SHIFT: begin
            if (clk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_done  <= 1'b1;
                frame_done <= last_flag;
              end
            end else if (clk_fall) begin
              if (bit_cnt != 3'd0) begin
`ifdef SPI_SEND_LSB_FIRST_EN
                shreg    <= {1'b0, shreg[7:1]};
                spi_miso <= shreg[1];
`else
                shreg    <= {shreg[6:0], 1'b0};
                spi_miso <= shreg[6];
`endif
              end else if (byte_done) begin
                state <= LOAD;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_send.sv
// Directed self-checking bench for spi_send (default depth 16, IDLE_BYTE 8'hFF).
module tb_spi_send;

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       axis_tvalid;
  logic       axis_tready;
  logic [7:0] axis_tdata;
  logic       axis_tlast;
  logic       underrun;
  logic       frame_done;

  int checks = 0;
  int failures = 0;
  int und_cnt = 0;
  int fd_cnt = 0;

  spi_send #(.FIFO_DEPTH(16), .IDLE_BYTE(8'hFF)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .axis_tvalid (axis_tvalid),
    .axis_tready (axis_tready),
    .axis_tdata  (axis_tdata),
    .axis_tlast  (axis_tlast),
    .underrun    (underrun),
    .frame_done  (frame_done)
  );

  always #5 axi_aclk = ~axi_aclk;

  always @(posedge axi_aclk) begin
    if (underrun === 1'b1)   und_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  task automatic push(input logic [7:0] d, input logic l, output bit ok);
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tlast  = l;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (axis_tready === 1'b1) ok = 1'b1;
      @(negedge axi_aclk);
    end
    axis_tvalid = 1'b0;
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    wait_cycles(8);
    chk("oe_selected", spi_miso_oe, 1'b1);
  endtask

  // seq holds bits in sampling order, first sampled bit ends up highest.
  task automatic spi_bits(input int n, input bit end_cs, output logic [7:0] seq);
    seq = '0;
    for (int i = 0; i < n; i++) begin
      wait_cycles(8);
      seq = {seq[6:0], spi_miso};
      spi_clk = 1'b1;
      wait_cycles(8);
      spi_clk = 1'b0;
      if (end_cs && i == n - 1) spi_cs = 1'b1;
    end
    if (end_cs) wait_cycles(8);
  endtask

  function automatic logic [7:0] to_byte(input logic [7:0] seq);
`ifdef SPI_SEND_LSB_FIRST_EN
    logic [7:0] r;
    for (int unsigned j = 0; j < 8; j++) r[j] = seq[7-j];
    return r;
`else
    return seq;
`endif
  endfunction

  initial begin
    logic [7:0] seq;
    bit ok;
    int u0, f0;

    axi_aresetn = 1'b0;
    spi_clk     = 1'b0;
    spi_cs      = 1'b1;
    axis_tvalid = 1'b0;
    axis_tdata  = '0;
    axis_tlast  = 1'b0;
    wait_cycles(3);
    chk("rst_tready", axis_tready, 1'b0);
    chk("rst_miso", spi_miso, 1'b1);
    chk("rst_oe", spi_miso_oe, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    axi_aresetn = 1'b1;
    chk("rel_tready_low", axis_tready, 1'b0);
    @(posedge axi_aclk); #1;
    chk("rel_tready_high", axis_tready, 1'b1);
    @(negedge axi_aclk);

    // Single A5 byte with tlast
    push(8'hA5, 1'b1, ok);
    chk("a5_push", ok, 1'b1);
    u0 = und_cnt; f0 = fd_cnt;
    cs_start();
    spi_bits(8, 1'b1, seq);
    chk("a5_byte", to_byte(seq), 8'hA5);
    chk("a5_frame_done", fd_cnt - f0, 1);
    chk("a5_underrun", und_cnt - u0, 0);
    chk("a5_oe_after", spi_miso_oe, 1'b0);
    chk("a5_miso_after", spi_miso, 1'b1);

    // Empty buffer
    u0 = und_cnt; f0 = fd_cnt;
    cs_start();
    spi_bits(8, 1'b1, seq);
    chk("empty_byte", to_byte(seq), 8'hFF);
    chk("empty_underrun", und_cnt - u0, 1);
    chk("empty_frame_done", fd_cnt - f0, 0);
    chk("empty_tready", axis_tready, 1'b1);

    // Fill to capacity, 17th accepted after first pop, drain across wrap
    for (int i = 0; i < 16; i++) begin
      push(8'h10 + 8'(i), 1'b0, ok);
      chk("fill_push", ok, 1'b1);
    end
    chk("full_tready", axis_tready, 1'b0);
    u0 = und_cnt; f0 = fd_cnt;
    cs_start();
    push(8'h20, 1'b1, ok);
    chk("push17_after_pop", ok, 1'b1);
    for (int i = 0; i < 17; i++) begin
      spi_bits(8, i == 16, seq);
      chk("wrap_byte", to_byte(seq), 8'h10 + 8'(i));
    end
    chk("wrap_frame_done", fd_cnt - f0, 1);
    chk("wrap_underrun", und_cnt - u0, 0);

    // Abort after 3 bits of 3C; next frame must carry 5A
    push(8'h3C, 1'b0, ok);
    push(8'h5A, 1'b1, ok);
    chk("abort_push", ok, 1'b1);
    u0 = und_cnt; f0 = fd_cnt;
    cs_start();
    spi_bits(3, 1'b1, seq);
    chk("abort_bits", seq[2:0], 3'b001);
    chk("abort_no_fd", fd_cnt - f0, 0);
    cs_start();
    spi_bits(8, 1'b1, seq);
    chk("abort_next_byte", to_byte(seq), 8'h5A);
    chk("abort_frame_done", fd_cnt - f0, 1);
    chk("abort_underrun", und_cnt - u0, 0);

    // Reset mid-byte
    push(8'h77, 1'b0, ok);
    push(8'h88, 1'b1, ok);
    chk("rstmid_push", ok, 1'b1);
    cs_start();
    spi_bits(4, 1'b0, seq);
    wait_cycles(2);
    axi_aresetn = 1'b0;
    #1;
    chk("rstmid_oe", spi_miso_oe, 1'b0);
    chk("rstmid_miso", spi_miso, 1'b1);
    chk("rstmid_tready", axis_tready, 1'b0);
    spi_cs  = 1'b1;
    spi_clk = 1'b0;
    wait_cycles(3);
    axi_aresetn = 1'b1;
    chk("rstmid_rel_low", axis_tready, 1'b0);
    @(posedge axi_aclk); #1;
    chk("rstmid_rel_high", axis_tready, 1'b1);
    @(negedge axi_aclk);
    u0 = und_cnt; f0 = fd_cnt;
    cs_start();
    spi_bits(8, 1'b1, seq);
    chk("rstmid_empty_byte", to_byte(seq), 8'hFF);
    chk("rstmid_underrun", und_cnt - u0, 1);
    chk("rstmid_frame_done", fd_cnt - f0, 0);

`ifdef SPI_SEND_LSB_FIRST_EN
    push(8'h01, 1'b1, ok);
    cs_start();
    spi_bits(8, 1'b1, seq);
    chk("lsb_first_01", seq, 8'b1000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_send.md
SPI_SEND -- requirements
Module: spi_send

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, byte-buffer depth; power of two, minimum 4.
REQ-002 Parameter IDLE_BYTE, default 8'hFF, byte shifted out when the buffer is empty at a byte boundary.
REQ-003 axi_aclk  input  1  sole clock; all logic is on its rising edge.
REQ-004 axi_aresetn  input  1  asynchronous, active-low reset.
REQ-005 spi_clk  input  1  SPI master clock, mode 0 (CPOL=0, CPHA=0), asynchronous to axi_aclk, at most axi_aclk/8.
REQ-006 spi_cs  input  1  chip select, active-low, asynchronous.
REQ-007 spi_miso  output  1  serial data to master.
REQ-008 spi_miso_oe  output  1  tristate enable for spi_miso, high while selected.
REQ-009 axis_tvalid  input  1  AXI4-Stream source valid.
REQ-010 axis_tready  output  1  AXI4-Stream sink ready.
REQ-011 axis_tdata  input  8  byte to transmit.
REQ-012 axis_tlast  input  1  marks the final byte of a frame.
REQ-013 underrun  output  1  one-cycle pulse when IDLE_BYTE is substituted.
REQ-014 frame_done  output  1  one-cycle pulse when the last bit of a tlast byte has been sampled.

Function
REQ-015 spi_clk and spi_cs SHALL pass through 2-flop synchronizers plus one history flop; edges SHALL be detected from the synchronized and history stages (3-cycle detection latency).
REQ-016 The buffer SHALL store {tlast, tdata}; axis_tready = !full; a push occurs on tvalid && tready.
REQ-017 FSM states: IDLE, LOAD, SHIFT; reset state IDLE.
REQ-018 IDLE: spi_miso_oe=0, spi_miso=1; a cs falling edge -> LOAD.
REQ-019 LOAD (one cycle): pop the head into the shift register if non-empty, else load IDLE_BYTE with last flag 0 and pulse underrun; drive bit 7 on spi_miso; set spi_miso_oe=1; bit counter=0; -> SHIFT.
REQ-020 SHIFT: each synchronized spi_clk rising edge increments the 3-bit counter; the rising edge that wraps the counter from 7 to 0 completes the byte and pulses frame_done if its last flag is set.
REQ-021 SHIFT: a spi_clk falling edge with counter != 0 shifts the register left and drives the next bit; a falling edge with counter == 0 after a completed byte -> LOAD.
REQ-022 A cs rising edge in any state -> IDLE next cycle; the partial byte is discarded and not re-queued; no frame_done.
REQ-023 A push and pop in the same cycle SHALL both succeed; a pop from an empty buffer in the same cycle as a push SHALL take the underrun path, and the pushed byte remains queued.
REQ-024 Buffer pointers SHALL be log2(FIFO_DEPTH)+1 bits wide; full and empty are derived from MSB and index comparison; wrap-around SHALL be seamless.

Reset
REQ-025 Asserting axi_aresetn low SHALL asynchronously clear FSM, counters, pointers and synchronizers (cs synchronizer to 1), with spi_miso=1, spi_miso_oe=0, axis_tready=0, underrun=0 and frame_done=0.
REQ-026 axis_tready SHALL rise on the first clock after reset release; a transfer in progress when reset is asserted is lost.

Configuration
REQ-027 With SPI_SEND_LSB_FIRST_EN defined, LOAD SHALL drive bit 0 and shifting SHALL be rightward (LSB first); without it, the block is MSB first as specified above.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the 9-bit buffer entry type and the IDLE_BYTE default.
REQ-029 The buffer SHALL be the sub-module spi_send_fifo (synchronous, single clock, first-word-fall-through).

Verification
REQ-030 Push 8'hA5 with tlast=1, then run a CS frame of 8 clocks -> MISO samples 1,0,1,0,0,1,0,1; one frame_done pulse; no underrun.
REQ-031 CS frame with an empty buffer -> 8'hFF is shifted, underrun pulses once, and axis_tready stays 1.
REQ-032 Push 17 bytes with depth 16 -> axis_tready falls after 16 bytes; the 17th byte is accepted after the first pop, and all 17 bytes arrive in order across the wrap.
REQ-033 Deassert CS after 3 clocks of 8'h3C, then start a new frame -> the next queued byte is sent and 8'h3C is not resent.
REQ-034 Assert reset mid-byte -> spi_miso_oe=0 and spi_miso=1 within the same cycle, the buffer is empty after release, and axis_tready rises one cycle later.
REQ-035 With SPI_SEND_LSB_FIRST_EN defined, send 8'h01 -> first sampled bit is 1, remaining bits are 0.
